fifo: RTL and testbench



---
 rtl/fifo_pkg.sv | 16 +
 rtl/fifo_mem.sv | 31 +++
 rtl/fifo.sv | 83 ++++++++
 tb/tb_fifo.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants for the single-clock FIFO: default geometry and the
// pointer-width helper (one extra wrap bit above the array address).
package fifo_pkg;

  localparam int DATA_SIZE_DEF = 8;
  localparam int ADDR_SIZE_DEF = 3;

  // Pointers carry one wrap bit above the array address so full and empty
  // can be told apart when the address bits match.
  function automatic int ptr_width(input int addr_size);
    return addr_size + 1;
  endfunction

  localparam int PTR_W_DEF = ADDR_SIZE_DEF + 1;

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage array: synchronous write port, asynchronous read port.
// Contents are never reset; validity is tracked by the pointers in the top.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 wr_en_i,
  input  logic [ADDR_SIZE-1:0] wr_addr_i,
  input  logic [DATA_SIZE-1:0] wr_data_i,
  input  logic [ADDR_SIZE-1:0] rd_addr_i,
  output logic [DATA_SIZE-1:0] rd_data_o
);

  localparam int DEPTH = 1 << ADDR_SIZE;

  logic [DATA_SIZE-1:0] mem_q [DEPTH];

  // Store the incoming word on an accepted write.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Head word is visible without a pop (first-word fall-through).
  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/fifo.sv
// Single-clock first-word-fall-through FIFO with full/empty flags.
// Optional occupancy output enabled by defining FIFO_LEVEL_EN.
module fifo
  import fifo_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 wr_en,
  input  logic [DATA_SIZE-1:0] wr_data,
  input  logic                 rd_en,
  output logic [DATA_SIZE-1:0] rd_data,
  output logic                 wfull,
`ifdef FIFO_LEVEL_EN
  output logic [ADDR_SIZE:0]   level,
`endif
  output logic                 rempty
);

  localparam int PTR_W = ptr_width(ADDR_SIZE);

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic                 wr_accept;
  logic                 rd_accept;
  logic [DATA_SIZE-1:0] mem_rd_data;

  // Flags come straight from the registered pointers, so they follow reset
  // immediately and reflect the state before each edge.
  assign rempty = (wr_ptr_q == rd_ptr_q);
  assign wfull  = (wr_ptr_q[ADDR_SIZE-1:0] == rd_ptr_q[ADDR_SIZE-1:0]) &&
                  (wr_ptr_q[ADDR_SIZE] != rd_ptr_q[ADDR_SIZE]);

  // Requests against a full/empty queue are simply dropped.
  assign wr_accept = wr_en && !wfull;
  assign rd_accept = rd_en && !rempty;

  // Advance each pointer only on its own accepted request.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (rd_accept) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  // Pointer registers; reset discards all buffered data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  fifo_mem #(
    .DATA_SIZE (DATA_SIZE),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (wr_accept),
    .wr_addr_i (wr_ptr_q[ADDR_SIZE-1:0]),
    .wr_data_i (wr_data),
    .rd_addr_i (rd_ptr_q[ADDR_SIZE-1:0]),
    .rd_data_o (mem_rd_data)
  );

  // Mask stale array contents while nothing is buffered.
  assign rd_data = rempty ? '0 : mem_rd_data;

`ifdef FIFO_LEVEL_EN
  // Modular difference of the pointers gives 0..2^ADDR_SIZE.
  assign level = wr_ptr_q - rd_ptr_q;
`endif

endmodule

// File: tb/tb_fifo.sv
// Directed self-checking bench for fifo (depth 8, 8-bit data).
module tb_fifo;

  logic       clk;
  logic       rstn;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       wfull;
  logic       rempty;
`ifdef FIFO_LEVEL_EN
  logic [3:0] level;
`endif

  int checks;
  int failures;
  logic [7:0] model_q[$];

  fifo #(.DATA_SIZE(8), .ADDR_SIZE(3)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .wfull   (wfull),
`ifdef FIFO_LEVEL_EN
    .level   (level),
`endif
    .rempty  (rempty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_level(input string tag, input int exp);
`ifdef FIFO_LEVEL_EN
    chk(tag, 32'(level), 32'(exp));
`else
    if (exp < 0) $display("unused level %s", tag);
`endif
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rstn = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    wr_data = 8'h00;

    // Reset held for 4 cycles
    repeat (4) tick();
    chk("rst_rempty", 32'(rempty), 32'd1);
    chk("rst_wfull", 32'(wfull), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk_level("rst_level", 0);
    $display("reset: rempty=%0d wfull=%0d rd_data=%02h", rempty, wfull, rd_data);
    rstn = 1'b1;
    repeat (2) tick();
    chk("idle_rempty", 32'(rempty), 32'd1);
    chk("idle_wfull", 32'(wfull), 32'd0);

    // Pass-through with rd_en held high
    rd_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      logic [7:0] v;
      v = 8'(8'h24 + i * 8'h11);
      wr_en = 1'b1;
      wr_data = v;
      tick();
      wr_en = 1'b0;
      chk("pt_rd_data", 32'(rd_data), 32'(v));
      chk("pt_rempty", 32'(rempty), 32'd0);
      tick();
      chk("pt_empty_after", 32'(rempty), 32'd1);
      chk("pt_zero_after", 32'(rd_data), 32'd0);
      $display("passthru: word %0d data=%02h", i, v);
    end

    // Overflow: 11 writes into depth 8
    rd_en = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(i);
      tick();
      chk("ovf_wfull", 32'(wfull), (i >= 8) ? 32'd1 : 32'd0);
      chk("ovf_head", 32'(rd_data), 32'h01);
      $display("overflow: write %02h wfull=%0d", i, wfull);
    end
    wr_en = 1'b0;
    chk_level("ovf_level", 8);

    // Drain: 8 valid words, then 3 reads from empty
    rd_en = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      chk("drain_data", 32'(rd_data), (i <= 8) ? 32'(i) : 32'd0);
      chk("drain_rempty", 32'(rempty), (i <= 8) ? 32'd0 : 32'd1);
      $display("drain: read %0d data=%02h", i, rd_data);
      tick();
    end
    chk("drain_end_rempty", 32'(rempty), 32'd1);
    chk("drain_end_wfull", 32'(wfull), 32'd0);
    chk("drain_end_data", 32'(rd_data), 32'd0);

    // Full with simultaneous write and read: only the read is accepted
    rd_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(8'h31 + i);
      tick();
    end
    chk("bfull_wfull", 32'(wfull), 32'd1);
    wr_en = 1'b1;
    rd_en = 1'b1;
    wr_data = 8'h99;
    tick();
    chk("bfull_wfull_after", 32'(wfull), 32'd0);
    chk("bfull_head", 32'(rd_data), 32'h32);
    chk_level("bfull_level", 7);
    $display("full rd+wr: wfull=%0d head=%02h", wfull, rd_data);
    wr_en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk("bfull_drain", 32'(rd_data), 32'(8'h32 + i));
      tick();
    end
    chk("bfull_drained", 32'(rempty), 32'd1);

    // Empty with simultaneous write and read: only the write is accepted
    wr_en = 1'b1;
    rd_en = 1'b1;
    wr_data = 8'h5A;
    tick();
    chk("bempty_rempty", 32'(rempty), 32'd0);
    chk("bempty_data", 32'(rd_data), 32'h5A);
    chk_level("bempty_level", 1);
    $display("empty rd+wr: rempty=%0d head=%02h", rempty, rd_data);
    wr_en = 1'b0;
    tick();
    chk("bempty_popped", 32'(rempty), 32'd1);

    // Wrap: preload 3 words, then 20 simultaneous write/read pairs
    rd_en = 1'b0;
    wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_data = 8'(8'hA0 + i);
      model_q.push_back(wr_data);
      tick();
    end
    rd_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wr_data = 8'(8'hC0 + i);
      chk("wrap_head", 32'(rd_data), 32'(model_q[0]));
      $display("wrap: pair %0d head=%02h write=%02h", i, rd_data, wr_data);
      tick();
      void'(model_q.pop_front());
      model_q.push_back(wr_data);
    end
    wr_en = 1'b0;
    while (model_q.size() > 0) begin
      chk("wrap_drain", 32'(rd_data), 32'(model_q[0]));
      tick();
      void'(model_q.pop_front());
    end
    chk("wrap_empty", 32'(rempty), 32'd1);

    // Mid-operation asynchronous reset with 5 words buffered
    rd_en = 1'b0;
    wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_data = 8'(8'h70 + i);
      tick();
    end
    wr_en = 1'b0;
    chk("mid_pre_rempty", 32'(rempty), 32'd0);
    chk_level("mid_pre_level", 5);
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_rst_rempty", 32'(rempty), 32'd1);
    chk("mid_rst_wfull", 32'(wfull), 32'd0);
    chk("mid_rst_data", 32'(rd_data), 32'd0);
    chk_level("mid_rst_level", 0);
    $display("mid reset: rempty=%0d wfull=%0d rd_data=%02h", rempty, wfull, rd_data);
    rstn = 1'b1;
    tick();
    chk("post_rst_rempty", 32'(rempty), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
